// File: rtl/pwm_capture.sv
// pwm_capture
//   Single-channel PWM measurement block on the peripheral register bus.
//   It measures the rising-to-rising period and the high time of a PWM input
//   in prescaled clock ticks. Each completed measurement is latched as a
//   coherent pair, flagged in STATUS and optionally signalled on irq_o.
//
// Ports
//   clk_i    block clock
//   rst_i    asynchronous active-high reset
//   re_i     register read strobe (a write needs we_i & ~re_i)
//   we_i     register write strobe
//   addr_i   byte address of the register
//   wdata_i  write data
//   be_i     byte enables (accepted, unused: full-word writes)
//   rdata_o  combinational read data for addr_i, 0 for unmapped addresses
//   pwm_i    asynchronous PWM input
//   irq_o    STATUS.valid & CTRL.irq_en
//
// Register map
//   0x00 CTRL    RW [2:0]  enable, irq_en, invert
//   0x04 DIVISOR RW        prescaler value (0 behaves as 1); a write clears the prescaler
//   0x08 PERIOD  RO        last rising-to-rising interval in ticks
//   0x0C HIGH    RO        last high time in ticks
//   0x10 STATUS  W1C [1:0] valid, overflow (sticky; set wins over clear)
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        re_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] rdata_o,
  input  logic        pwm_i,
  output logic        irq_o
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_DIVISOR = 8'h04;
  localparam logic [7:0] ADDR_PERIOD  = 8'h08;
  localparam logic [7:0] ADDR_HIGH    = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HIGH_PH = 2'd1;
  localparam logic [1:0] ST_LOW_PH  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Register state
  logic             enable;
  logic             irq_en;
  logic             invert;
  logic [CNT_W-1:0] divisor;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             overflow;

  // Measurement state
  logic [1:0]       state;
  logic [CNT_W-1:0] p;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_lat;

  // Input path
  logic sync1;
  logic sync2;
  logic s;
  logic s_q;
  logic rise;
  logic fall;

  // Decoded strobes and datapath terms
  logic             wr;
  logic             ctrl_wr;
  logic             div_wr;
  logic             status_wr;
  logic [CNT_W-1:0] div_eff;
  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic             capture;
  logic             ovf_evt;

  // Byte enables and the upper write-data bits have no function here.
  logic unused_bits;
  assign unused_bits = ^{be_i, wdata_i[31:CNT_W]};

  assign wr        = we_i & ~re_i;
  assign ctrl_wr   = wr && (addr_i == ADDR_CTRL);
  assign div_wr    = wr && (addr_i == ADDR_DIVISOR);
  assign status_wr = wr && (addr_i == ADDR_STATUS);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detection
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so that all flops
  // sample their inputs from the same edge, regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      s_q   <= 1'b0;
    end else begin
      sync1 <= pwm_i;
      sync2 <= sync1;
      s_q   <= s;
    end
  end

  assign s    = sync2 ^ invert;
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      enable  <= 1'b0;
      irq_en  <= 1'b0;
      invert  <= 1'b0;
      divisor <= '0;
    end else begin
      if (ctrl_wr) begin
        enable <= wdata_i[0];
        irq_en <= wdata_i[1];
        invert <= wdata_i[2];
      end
      if (div_wr) begin
        divisor <= wdata_i[CNT_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler
  // ---------------------------------------------------------------------------
  assign div_eff = (divisor == '0) ? CNT_ONE : divisor;
  assign tick    = enable && (p == div_eff - CNT_ONE);
  assign cnt_inc = cnt + CNT_W'(tick);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p <= '0;
    end else if (!enable || div_wr || tick) begin
      p <= '0;
    end else begin
      p <= p + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  // The counter runs from one rising edge to the next; the high time is
  // snapshotted at the falling edge without disturbing the count.
  assign capture = enable && (state == ST_LOW_PH) && rise;
  assign ovf_evt = (state != ST_IDLE) && (cnt == CNT_MAX) && tick && !rise && !fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_lat <= '0;
    end else if (!enable) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi_lat <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= ST_HIGH_PH;
          end
        end
        ST_HIGH_PH: begin
          if (rise) begin
            // Only reachable through a spurious edge; restart the interval.
            cnt <= '0;
          end else if (fall) begin
            hi_lat <= cnt_inc;
            cnt    <= cnt_inc;
            state  <= ST_LOW_PH;
          end else if (ovf_evt) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_LOW_PH: begin
          if (rise) begin
            cnt   <= '0;
            state <= ST_HIGH_PH;
          end else if (ovf_evt) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (capture) begin
        period    <= cnt_inc;
        high_time <= hi_lat;
      end
      // A set event in the same cycle as a write-1-to-clear keeps the bit set.
      valid    <= (valid    & ~(status_wr & wdata_i[0])) | capture;
      overflow <= (overflow & ~(status_wr & wdata_i[1])) | ovf_evt;
    end
  end

  assign irq_o = valid & irq_en;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  // NOTE: rdata_o gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      ADDR_CTRL:    rdata_o[2:0]       = {invert, irq_en, enable};
      ADDR_DIVISOR: rdata_o[CNT_W-1:0] = divisor;
      ADDR_PERIOD:  rdata_o[CNT_W-1:0] = period;
      ADDR_HIGH:    rdata_o[CNT_W-1:0] = high_time;
      ADDR_STATUS:  rdata_o[1:0]       = {overflow, valid};
      default:      rdata_o            = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture.
// Directed checks cover reset, capture latency, set-wins W1C, inversion,
// overflow and reset during a measurement. Randomized PWM waveforms are
// scored by a monitor that pops expected (period, high) pairs from a queue
// each time the block raises its interrupt.
module tb_pwm_capture;

  localparam logic [7:0] A_CTRL    = 8'h00;
  localparam logic [7:0] A_DIVISOR = 8'h04;
  localparam logic [7:0] A_PERIOD  = 8'h08;
  localparam logic [7:0] A_HIGH    = 8'h0C;
  localparam logic [7:0] A_STATUS  = 8'h10;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] high;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        re;
  logic        we;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        pwm;
  logic        irq;

  // Bus is owned by the main sequence, or by the monitor while mon_en is set.
  logic        mon_en;
  logic [7:0]  d_addr, m_addr;
  logic [31:0] d_wdata, m_wdata;
  logic        d_we, m_we;

  assign addr  = mon_en ? m_addr  : d_addr;
  assign wdata = mon_en ? m_wdata : d_wdata;
  assign we    = mon_en ? m_we    : d_we;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  pwm_capture #(.CNT_W(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .re_i    (re),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .rdata_o (rdata),
    .pwm_i   (pwm),
    .irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    d_addr  = a;
    d_wdata = d;
    d_we    = 1'b1;
    @(negedge clk);
    d_we    = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
    d_addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  // One PWM period of 'hi' high cycles then 'lo' low cycles.
  task automatic pulse(input int hi, input int lo);
    pwm = 1'b1;
    wait_cyc(hi);
    pwm = 1'b0;
    wait_cyc(lo);
  endtask

  // Scoreboard monitor: each interrupt means a fresh capture is visible.
  initial begin
    exp_t e;
    m_addr  = A_STATUS;
    m_wdata = '0;
    m_we    = 1'b0;
    forever begin
      @(negedge clk);
      if (m_we) begin
        m_we = 1'b0;
      end else if (mon_en && irq) begin
        check("sb_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          m_addr = A_PERIOD;
          #1;
          check("sb_period", rdata, {16'h0, e.period});
          m_addr = A_HIGH;
          #1;
          check("sb_high", rdata, {16'h0, e.high});
        end
        m_addr  = A_STATUS;
        m_wdata = 32'h1;
        m_we    = 1'b1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int divs[5];
    int de, h, l, ph, pl;

    rst     = 1'b1;
    re      = 1'b0;
    be      = 4'hF;
    pwm     = 1'b0;
    mon_en  = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_we    = 1'b0;

    // Reset state: every register reads 0 while reset is held.
    wait_cyc(3);
    check_reg("rst_ctrl",    A_CTRL,    32'h0);
    check_reg("rst_divisor", A_DIVISOR, 32'h0);
    check_reg("rst_period",  A_PERIOD,  32'h0);
    check_reg("rst_high",    A_HIGH,    32'h0);
    check_reg("rst_status",  A_STATUS,  32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    rst = 1'b0;
    wait_cyc(2);

    // Basic capture at DIVISOR=1 with 3-cycle latency from the input edge.
    bus_write(A_DIVISOR, 32'd1);
    bus_write(A_CTRL,    32'd3);
    wait_cyc(3);
    pulse(3, 7);
    pwm = 1'b1;
    wait_cyc(2);
    check("lat_irq_early", 32'(irq), 32'h0);
    wait_cyc(1);
    check("lat_irq_on", 32'(irq), 32'h1);
    check_reg("t1_period", A_PERIOD, 32'd10);
    check_reg("t1_high",   A_HIGH,   32'd3);
    check_reg("t1_status", A_STATUS, 32'h1);

    // W1C landing on the capture edge: set wins. One cycle later it clears.
    pwm = 1'b0;
    wait_cyc(7);
    pwm = 1'b1;
    wait_cyc(2);
    bus_write(A_STATUS, 32'h1);
    pwm = 1'b0;
    check_reg("w1c_same_status", A_STATUS, 32'h1);
    check_reg("w1c_same_period", A_PERIOD, 32'd10);
    bus_write(A_STATUS, 32'h1);
    check_reg("w1c_late_status", A_STATUS, 32'h0);
    check("w1c_late_irq", 32'(irq), 32'h0);
    wait_cyc(6);

    // Randomized waveforms with intervals that are multiples of the divisor.
    divs = '{0, 1, 2, 4, 3};
    divs[4] = int'($urandom_range(3, 6));
    foreach (divs[r]) begin
      de = (divs[r] == 0) ? 1 : divs[r];
      bus_write(A_CTRL,    32'd0);
      bus_write(A_DIVISOR, 32'(divs[r]));
      bus_write(A_STATUS,  32'h3);
      bus_write(A_CTRL,    32'd3);
      mon_en = 1'b1;
      wait_cyc(3);
      ph = 0;
      pl = 0;
      for (int k = 0; k < 6; k++) begin
        h = int'($urandom_range(3, 10));
        l = int'($urandom_range(3, 10));
        if (r == 3 && k < 2) begin
          h = 3;
          l = 7;
        end
        if (k > 0) sb.push_back('{period: 16'(ph + pl), high: 16'(ph)});
        pulse(h * de, l * de);
        ph = h;
        pl = l;
      end
      sb.push_back('{period: 16'(ph + pl), high: 16'(ph)});
      pulse(3 * de, 5);
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      wait_cyc(4);
      check("sb_drained", 32'(sb.size()), 32'd0);
      mon_en = 1'b0;
    end

    // Inverted input: the captured high time is the PWM low time.
    bus_write(A_CTRL,    32'd0);
    bus_write(A_DIVISOR, 32'd1);
    bus_write(A_STATUS,  32'h3);
    bus_write(A_CTRL,    32'd6);
    wait_cyc(3);
    bus_write(A_CTRL,    32'd7);
    wait_cyc(3);
    for (int k = 0; k < 4; k++) pulse(3, 7);
    check_reg("inv_period", A_PERIOD, 32'd10);
    check_reg("inv_high",   A_HIGH,   32'd7);
    check_reg("inv_status", A_STATUS, 32'h1);

    // Overflow: input held high far longer than the counter range.
    bus_write(A_CTRL,   32'd0);
    bus_write(A_STATUS, 32'h3);
    bus_write(A_CTRL,   32'd1);
    wait_cyc(3);
    pwm = 1'b1;
    wait_cyc(70000);
    check_reg("ovf_status", A_STATUS, 32'h2);
    check_reg("ovf_period", A_PERIOD, 32'd10);
    check_reg("ovf_high",   A_HIGH,   32'd7);
    // Back in IDLE: one fall and one rise must not produce a capture.
    pwm = 1'b0;
    wait_cyc(5);
    pwm = 1'b1;
    wait_cyc(5);
    check_reg("ovf_idle_status", A_STATUS, 32'h2);
    bus_write(A_STATUS, 32'h2);
    check_reg("ovf_clr_status", A_STATUS, 32'h0);
    pwm = 1'b0;
    wait_cyc(5);

    // Reset pulsed during the low phase, then a fresh two-rise measurement.
    bus_write(A_CTRL,   32'd0);
    bus_write(A_STATUS, 32'h3);
    bus_write(A_CTRL,   32'd3);
    wait_cyc(3);
    pulse(3, 7);
    pulse(3, 4);
    check("rstmid_pre_irq", 32'(irq), 32'h1);
    rst = 1'b1;
    check_reg("rstmid_ctrl",    A_CTRL,    32'h0);
    check_reg("rstmid_divisor", A_DIVISOR, 32'h0);
    check_reg("rstmid_period",  A_PERIOD,  32'h0);
    check_reg("rstmid_high",    A_HIGH,    32'h0);
    check_reg("rstmid_status",  A_STATUS,  32'h0);
    check("rstmid_irq", 32'(irq), 32'h0);
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    bus_write(A_DIVISOR, 32'd1);
    bus_write(A_CTRL,    32'd3);
    wait_cyc(3);
    pulse(3, 7);
    check_reg("rstmid_one_rise", A_STATUS, 32'h0);
    pwm = 1'b1;
    wait_cyc(3);
    check_reg("rstmid_cap_status", A_STATUS, 32'h1);
    check_reg("rstmid_cap_period", A_PERIOD, 32'd10);
    check_reg("rstmid_cap_high",   A_HIGH,   32'd3);
    check("rstmid_cap_irq", 32'(irq), 32'h1);
    pwm = 1'b0;
    wait_cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
